// File: rtl/demux_1x4_buf.sv
// demux_1x4_buf: 1-to-4 demultiplexer with a one-word holding buffer per channel.
//
// A word presented on in_data with in_valid is steered to the channel chosen by
// in_sel and held there until that channel's consumer takes it (out_valid[k] &
// out_ready[k]). Each channel has its own full flag, so a stalled channel never
// blocks traffic to the others. A per-channel 8-bit counter tracks delivered words.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   in_data      in   [N-1:0] payload
//   in_sel       in   [1:0] destination channel
//   in_valid     in   payload valid this cycle
//   in_ready     out  addressed channel can take a word this cycle
//   out_data_xx  out  [N-1:0] held payload, channel xx
//   out_valid    out  [3:0] channel k holds a word
//   out_ready    in   [3:0] consumer of channel k takes the word
//   busy         out  any channel holds a word
//   xfer_cnt_xx  out  [7:0] delivered-word count, channel xx (wraps)

module demux_1x4_buf #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in_data,
  input  logic [1:0]   in_sel,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] out_data_00,
  output logic [N-1:0] out_data_01,
  output logic [N-1:0] out_data_10,
  output logic [N-1:0] out_data_11,
  output logic [3:0]   out_valid,
  input  logic [3:0]   out_ready,
  output logic         busy,
  output logic [7:0]   xfer_cnt_00,
  output logic [7:0]   xfer_cnt_01,
  output logic [7:0]   xfer_cnt_10,
  output logic [7:0]   xfer_cnt_11
);

  logic [N-1:0] data_q [4];
  logic [N-1:0] data_d [4];
  logic [3:0]   full_q;
  logic [3:0]   full_d;
  logic [7:0]   cnt_q  [4];
  logic [7:0]   cnt_d  [4];

  logic       accept;
  logic [3:0] load;
  logic [3:0] xfer;

  // Only the addressed channel's state feeds in_ready; a full channel can still
  // accept when its consumer drains it in the same cycle.
  always_comb begin
    in_ready = !full_q[in_sel] || out_ready[in_sel];
    accept   = in_valid && in_ready;
  end

  always_comb begin
    load = '0;
    xfer = '0;
    for (int k = 0; k < 4; k++) begin
      load[k]   = accept && (in_sel == 2'(k));
      xfer[k]   = full_q[k] && out_ready[k];
      // A load wins over a drain, so a simultaneous drain+load keeps full set.
      full_d[k] = load[k] || (full_q[k] && !xfer[k]);
      data_d[k] = load[k] ? in_data : data_q[k];
      cnt_d[k]  = cnt_q[k] + 8'(xfer[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= '0;
      for (int k = 0; k < 4; k++) begin
        data_q[k] <= '0;
        cnt_q[k]  <= '0;
      end
    end else begin
      full_q <= full_d;
      for (int k = 0; k < 4; k++) begin
        data_q[k] <= data_d[k];
        cnt_q[k]  <= cnt_d[k];
      end
    end
  end

  always_comb begin
    out_valid   = full_q;
    busy        = |full_q;
    out_data_00 = data_q[0];
    out_data_01 = data_q[1];
    out_data_10 = data_q[2];
    out_data_11 = data_q[3];
    xfer_cnt_00 = cnt_q[0];
    xfer_cnt_01 = cnt_q[1];
    xfer_cnt_10 = cnt_q[2];
    xfer_cnt_11 = cnt_q[3];
  end

endmodule

// File: tb/tb_demux_1x4_buf.sv
module tb_demux_1x4_buf;

  localparam int unsigned N = 32;

  logic         clk;
  logic         rst;
  logic [N-1:0] in_data;
  logic [1:0]   in_sel;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] out_data_00, out_data_01, out_data_10, out_data_11;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
  logic         busy;
  logic [7:0]   xfer_cnt_00, xfer_cnt_01, xfer_cnt_10, xfer_cnt_11;

  demux_1x4_buf #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data_00(out_data_00),
    .out_data_01(out_data_01),
    .out_data_10(out_data_10),
    .out_data_11(out_data_11),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .xfer_cnt_00(xfer_cnt_00),
    .xfer_cnt_01(xfer_cnt_01),
    .xfer_cnt_10(xfer_cnt_10),
    .xfer_cnt_11(xfer_cnt_11)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  logic [N-1:0] od  [4];
  logic [7:0]   oc  [4];
  assign od[0] = out_data_00;
  assign od[1] = out_data_01;
  assign od[2] = out_data_10;
  assign od[3] = out_data_11;
  assign oc[0] = xfer_cnt_00;
  assign oc[1] = xfer_cnt_01;
  assign oc[2] = xfer_cnt_10;
  assign oc[3] = xfer_cnt_11;

  int checks   = 0;
  int failures = 0;

  // Scoreboard: per-channel queues of words the bench expects to see delivered.
  logic [N-1:0] sb [4][$];
  // Bench-side model of channel occupancy and delivery counts.
  logic [3:0]   full_m;
  logic [7:0]   cnt_m [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: whenever a channel presents a word that its consumer takes, pop and compare.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
        for (int k = 0; k < 4; k++) begin
          if (out_valid[k] === 1'b1 && out_ready[k] === 1'b1) begin
            if (sb[k].size() == 0) begin
              checks++;
              failures++;
              $display("FAIL spurious_ch%0d: got word %0h expected none", k, od[k]);
            end else begin
              chk($sformatf("data_ch%0d", k), 64'(od[k]), 64'(sb[k].pop_front()));
            end
          end
        end
      end
    end
  end

  // One cycle of stimulus. Entered and left at posedge+1.
  task automatic step(input logic v, input logic [1:0] s, input logic [N-1:0] d,
                      input logic [3:0] r, input logic rs = 1'b0);
    logic exp_ready;
    logic acc;
    rst       = rs;
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
    exp_ready = !full_m[s] || r[s];
    acc       = v && exp_ready;
    if (!rs && acc) sb[s].push_back(d);
    @(negedge clk);
    chk("in_ready", 64'(in_ready), 64'(exp_ready));
    chk("out_valid", 64'(out_valid), 64'(full_m));
    chk("busy", 64'(busy), 64'(|full_m));
    for (int k = 0; k < 4; k++) chk($sformatf("cnt_ch%0d", k), 64'(oc[k]), 64'(cnt_m[k]));
    @(posedge clk);
    #1;
    if (rs) begin
      full_m = '0;
      for (int k = 0; k < 4; k++) begin
        cnt_m[k] = '0;
        sb[k].delete();
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        logic xf;
        logic ld;
        xf = full_m[k] && r[k];
        ld = acc && (s == 2'(k));
        full_m[k] = ld || (full_m[k] && !xf);
        cnt_m[k]  = cnt_m[k] + 8'(xf);
      end
    end
  endtask

  task automatic idle(input logic [3:0] r);
    step(1'b0, 2'd0, '0, r);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sel = '0; in_data = '0; out_ready = '0;
    full_m = '0;
    for (int k = 0; k < 4; k++) cnt_m[k] = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state and in_ready for every selector value.
    for (int k = 0; k < 4; k++) chk($sformatf("rst_data_ch%0d", k), 64'(od[k]), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s);
      #1;
      chk($sformatf("rst_in_ready_sel%0d", s), 64'(in_ready), 64'd1);
    end

    // Basic route to channel 2.
    step(1'b1, 2'b10, 32'hDEADBEEF, 4'b0000);
    chk("basic_valid", 64'(out_valid), 64'h4);
    chk("basic_data", 64'(out_data_10), 64'hDEADBEEF);
    chk("basic_busy", 64'(busy), 64'd1);
    step(1'b0, 2'b00, '0, 4'b0100);
    chk("basic_drain_valid", 64'(out_valid), 64'h0);
    chk("basic_cnt", 64'(xfer_cnt_10), 64'd1);

    // Backpressure on channel 1 must not block channel 3.
    step(1'b1, 2'b01, 32'h11, 4'b0000);
    step(1'b1, 2'b01, 32'h22, 4'b0000);
    chk("bp_hold_data", 64'(out_data_01), 64'h11);
    step(1'b1, 2'b11, 32'h33, 4'b0000);
    chk("bp_other_valid", 64'(out_valid), 64'hA);
    chk("bp_other_data", 64'(out_data_11), 64'h33);
    idle(4'b1111);
    idle(4'b0000);

    // Pass-through: simultaneous drain and load on channel 0.
    step(1'b1, 2'b00, 32'h1, 4'b0000);
    step(1'b1, 2'b00, 32'h2, 4'b0001);
    chk("pt_valid0", 64'(out_valid[0]), 64'd1);
    chk("pt_data", 64'(out_data_00), 64'h2);
    chk("pt_cnt", 64'(xfer_cnt_00), 64'd1);
    idle(4'b0001);

    // Streaming 300 words to channel 3 from a clean reset.
    step(1'b0, 2'b00, '0, 4'b0000, 1'b1);
    for (int i = 0; i < 300; i++) step(1'b1, 2'b11, N'(i + 1000), 4'b1000);
    idle(4'b1000);
    chk("stream_cnt", 64'(xfer_cnt_11), 64'd44);
    chk("stream_empty", 64'(sb[3].size()), 64'd0);

    // Mid-operation reset with all channels full and a word presented.
    step(1'b1, 2'b00, 32'hA0, 4'b0000);
    step(1'b1, 2'b01, 32'hA1, 4'b0000);
    step(1'b1, 2'b10, 32'hA2, 4'b0000);
    step(1'b1, 2'b11, 32'hA3, 4'b0000);
    chk("pre_rst_valid", 64'(out_valid), 64'hF);
    step(1'b1, 2'b10, 32'h99, 4'b1111, 1'b1);
    chk("mid_rst_valid", 64'(out_valid), 64'h0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    for (int k = 0; k < 4; k++) chk($sformatf("mid_rst_cnt_ch%0d", k), 64'(oc[k]), 64'd0);
    idle(4'b1111);

    // Random traffic against the scoreboard.
    for (int i = 0; i < 10000; i++)
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), N'($urandom),
           4'($urandom_range(0, 15)));
    idle(4'b1111);
    idle(4'b1111);
    for (int k = 0; k < 4; k++) chk($sformatf("final_empty_ch%0d", k), 64'(sb[k].size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
